// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU function codes,
// opcode classification helpers, FSM state encoding and flag bit positions.
package alu_pkg;

  localparam int ALU_DATA_W  = 16;
  localparam int ALU_REG_CNT = 16;
  localparam int REG_ADDR_W  = 4;
  localparam int CTRL_W      = 5;

  // ALU function codes; the instruction opcode maps 1:1 onto these.
  localparam logic [CTRL_W-1:0] ALU_ADD = 5'h0;
  localparam logic [CTRL_W-1:0] ALU_SUB = 5'h1;
  localparam logic [CTRL_W-1:0] ALU_AND = 5'h2;
  localparam logic [CTRL_W-1:0] ALU_OR  = 5'h3;
  localparam logic [CTRL_W-1:0] ALU_XOR = 5'h4;
  localparam logic [CTRL_W-1:0] ALU_SLL = 5'h5;
  localparam logic [CTRL_W-1:0] ALU_SRA = 5'h6;
  localparam logic [CTRL_W-1:0] ALU_LLB = 5'h8;
  localparam logic [CTRL_W-1:0] ALU_LHB = 5'h9;

  // Bit positions inside the {Z,N,V} flags vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Opcodes 7 and 10-15 have no ALU function behind them.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

  // ADD/SUB: the only ops whose V flag comes from the ALU.
  function automatic logic op_is_addsub(input logic [3:0] op);
    op_is_addsub = (op == 4'h0) || (op == 4'h1);
  endfunction

  // ADD..SRA update Z/N/V; byte loads leave flags alone.
  function automatic logic op_sets_flags(input logic [3:0] op);
    op_sets_flags = (op <= 4'h6);
  endfunction

  // Two-register ops take operand b from R[rt].
  function automatic logic op_uses_rt(input logic [3:0] op);
    op_uses_rt = (op <= 4'h4);
  endfunction

  // Shifts take operand b from the 4-bit immediate.
  function automatic logic op_is_shift(input logic [3:0] op);
    op_is_shift = (op == 4'h5) || (op == 4'h6);
  endfunction

  // LLB/LHB read R[rd] as operand a and an 8-bit immediate as operand b.
  function automatic logic op_is_byte_load(input logic [3:0] op);
    op_is_byte_load = (op == 4'h8) || (op == 4'h9);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue sequencer: two combinational read ports,
// one combinational debug read port and one synchronous write port.
// R0 is hardwired to zero; writes to it are discarded.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int REG_CNT = ALU_REG_CNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0]     ra_data,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0]     rb_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]     wd
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Storage update: clear on reset, otherwise write any register except R0.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is reset because reset must clear architectural
      // state; this keeps the file in flops rather than a RAM macro.
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      regs[wa] <= wd;
    end
  end

  // Read ports are plain muxes; R0 forced to zero independent of storage.
  assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Initiator side of the 16-bit combinational ALU interface.
// Accepts one instruction per handshake, issues registered operands to the
// ALU, captures the result and writes it back with a {Z,N,V} flag update.
// Sequence per instruction: IDLE(accept) -> ISSUE -> CAPT -> WB -> IDLE;
// illegal opcodes take IDLE -> ERR -> IDLE with no side effects.
// Optional build macro ALU_ISSUE_SAT_EN: saturate ADD/SUB results on overflow.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int REG_CNT = ALU_REG_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovfl,
  output logic              done,
  output logic              err,
  output logic [2:0]        flags,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t state_q, state_d;

  logic [3:0] f_op, f_rd, f_rs, f_rt;
  logic [7:0] f_imm8;
  logic       accept;

  logic [REG_ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0]     ra_data, rb_data, opnd_b;

  logic [3:0]        op_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] res_q;
  logic              ovfl_q;
  logic [DATA_W-1:0] wb_res;
  logic              wb_en;

  assign f_op   = instr[15:12];
  assign f_rd   = instr[11:8];
  assign f_rs   = instr[7:4];
  assign f_rt   = instr[3:0];
  assign f_imm8 = instr[7:0];

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign done        = (state_q == ST_WB);
  assign err         = (state_q == ST_ERR);
  assign wb_en       = (state_q == ST_WB);

  // Byte loads merge into the destination, so port a reads rd for them.
  assign ra_addr = op_is_byte_load(f_op) ? f_rd : f_rs;

  alu_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (ra_addr),
    .ra_data  (ra_data),
    .rb_addr  (f_rt),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wa       (rd_q),
    .wd       (wb_res)
  );

  // Operand b select: register, 4-bit shift amount or 8-bit immediate.
  always_comb begin
    // NOTE: default assigned first so no path leaves opnd_b unassigned,
    // which would otherwise infer a latch.
    opnd_b = rb_data;
    if (op_is_shift(f_op)) begin
      opnd_b = {{(DATA_W-4){1'b0}}, f_rt};
    end else if (op_is_byte_load(f_op)) begin
      opnd_b = {{(DATA_W-8){1'b0}}, f_imm8};
    end
  end

  // Writeback value: wrapped ALU result, optionally saturated on overflow.
  always_comb begin
    wb_res = res_q;
`ifdef ALU_ISSUE_SAT_EN
    if (op_is_addsub(op_q) && ovfl_q) begin
      wb_res = alu_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; every non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = op_legal(f_op) ? ST_ISSUE : ST_ERR;
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Issue registers: load operands on a legal accept, hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      op_q     <= '0;
      rd_q     <= '0;
    end else if (accept && op_legal(f_op)) begin
      alu_a    <= ra_data;
      alu_b    <= opnd_b;
      alu_ctrl <= {1'b0, f_op};
      op_q     <= f_op;
      rd_q     <= f_rd;
    end
  end

  // Capture registers: sample the combinational ALU at the end of CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      ovfl_q <= 1'b0;
    end else if (state_q == ST_CAPT) begin
      res_q  <= alu_out;
      ovfl_q <= alu_ovfl;
    end
  end

  // Status flags: updated at the edge ending WB for arithmetic/logic ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if ((state_q == ST_WB) && op_sets_flags(op_q)) begin
      flags[FLAG_Z] <= (wb_res == '0);
      flags[FLAG_N] <= wb_res[DATA_W-1];
      flags[FLAG_V] <= op_is_addsub(op_q) ? ovfl_q : 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the 16-bit ALU interface; the ALU itself is a purely combinational responder.
- Accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal register file.
- Drives a/b/ctrl to the ALU, captures out/ovfl, writes back the result and updates status flags.
- Sits between instruction fetch and the combinational ALU in the CPU datapath.

Parameters:
- DATA_W, 16, datapath and register width; only 16 is supported.
- REG_CNT, 16, register count; R0 reads as zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4; imm8 = [7:0]
- instr_ready  out  1  high only in IDLE
- alu_a  out  16  ALU operand a
- alu_b  out  16  ALU operand b
- alu_ctrl  out  5  ALU function code
- alu_out  in  16  ALU result
- alu_ovfl  in  1  ALU signed overflow
- done  out  1  one-cycle pulse on writeback
- err  out  1  one-cycle pulse on illegal opcode
- flags  out  3  {Z,N,V}
- dbg_addr  in  4  debug register read address
- dbg_data  out  16  combinational read of R[dbg_addr]

Behaviour:
- Reset values: all registers 0, flags 0, state IDLE, instr_ready=1, done=0, err=0, alu_a/alu_b=0, alu_ctrl=0.
- Opcode map (op = alu_ctrl):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: a=R[rs], b=R[rt].
  - 5 SLL, 6 SRA: a=R[rs], b={12'b0,imm4}.
  - 8 LLB, 9 LHB: a=R[rd], b={8'b0,imm8}.
  - 7 and 10-15 are illegal.
- States: IDLE -> ISSUE -> CAPT -> WB -> IDLE.
- IDLE:
  - Accept on instr_valid && instr_ready (edge T0); latch fields.
  - Legal op -> ISSUE. Illegal op -> ERR, which drives err=1 for one cycle with no writeback and no flag change, then IDLE.
- ISSUE (T0+1):
  - alu_a/alu_b/alu_ctrl are registered outputs, loaded at T0 from the RF read.
  - They hold stable through CAPT.
- CAPT (T0+2): register alu_out and alu_ovfl at the end of the cycle.
- WB (T0+3):
  - Write the result to R[rd] at the edge ending WB; a write to R0 is discarded.
  - done=1 for this cycle only.
  - Flag update:
    - ops 0-6: Z=(res==0), N=res[15].
    - ops 0/1: V=captured ovfl; ops 2-6: V=0.
    - ops 8/9: flags unchanged.
- Back in IDLE at T0+4; the next accept is possible at T0+4, giving a throughput of 1 instr per 4 cycles.
- Outside ISSUE/CAPT, alu_* hold their last values; no glitch requirement.
- dbg_data during WB shows the old value; the new value is visible from the next cycle.
- rs==rd or rt==rd: operands are read at accept, so pre-write values are used.
- instr_valid is ignored while instr_ready=0; instr changes while not ready have no effect.
- rst mid-operation: state goes to IDLE, the pending writeback is dropped, and all outputs return to reset values on the next cycle.
- ADD/SUB arithmetic is 16-bit wrap-around (without the optional feature).

Optional Feature:
- Macro: ALU_ISSUE_SAT_EN.
- Defined: on op 0/1 with captured ovfl=1, write back 16'h7FFF if alu_a[15]==0, else 16'h8000. V=1 is still set; Z/N are computed from the saturated value.
- Undefined: the wrapped alu_out is written.

Decomposition:
- alu_pkg holds:
  - ALU ctrl codes (ADD=5'h0, SUB=5'h1, AND=5'h2, OR=5'h3, XOR=5'h4, SLL=5'h5, SRA=5'h6, LLB=5'h8, LHB=5'h9);
  - opcode-legality function;
  - FSM state enum (IDLE, ISSUE, CAPT, WB, ERR);
  - flag bit indices.
- One sub-module, alu_regfile: 2 combinational read ports plus dbg read, 1 synchronous write port, R0 hardwired zero.

Test Plan:
- Reset, then LLB R1,0x34 and LHB R1,0x12 (R1 = 0x1234) -> done pulses at T0+3 of each; dbg_addr=1 reads 0x1234; flags unchanged at 0.
- R1=0x7FFF, R2=0x0001, ADD R3,R1,R2 -> alu_ctrl=0 during ISSUE; R3=0x8000, flags {Z,N,V}=3'b011. With ALU_ISSUE_SAT_EN: R3=0x7FFF, flags 3'b001.
- R1=0x0005, SUB R4,R1,R1 -> alu_ctrl=1; R4=0x0000, flags 3'b100.
- R1=0x8000, SRA R5,R1,#3 -> alu_b=0x0003, alu_ctrl=6; R5=0xF000, flags 3'b010.
- Illegal op 0xF -> err pulses once, no done; registers and flags unchanged; instr_ready high 2 cycles after accept.
- Back-to-back instr_valid held high, plus rst asserted during CAPT -> second instr not accepted until IDLE; after rst, R[rd] is unchanged (0), done never pulses, instr_ready=1.
